// File: rtl/uniboard_bus_pkg.sv
// Shared widths, state encoding and byte-mask helper for the uniboard register bus.
package uniboard_bus_pkg;

   localparam int unsigned ADDR_W        = 8;
   localparam int unsigned DATA_W        = 32;
   localparam int unsigned SIZE_W        = 3;
   localparam int unsigned CNT_W         = 4;
   localparam int unsigned MAX_REG_BYTES = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_RECOVER
   } bus_state_t;

   // Ones in the low `size` bytes; sizes outside 1..4 give an empty mask.
   function automatic logic [DATA_W-1:0] byte_mask(input logic [SIZE_W-1:0] size);
      logic [DATA_W-1:0] m;
      m = '0;
      case (size)
         3'd1:    m = DATA_W'(32'h0000_00FF);
         3'd2:    m = DATA_W'(32'h0000_FFFF);
         3'd3:    m = DATA_W'(32'h00FF_FFFF);
         3'd4:    m = DATA_W'(32'hFFFF_FFFF);
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/uniboard_bus_master_if.sv
// Command/response handshake between a command source and the uniboard bus master.
interface uniboard_bus_master_if;
   import uniboard_bus_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_rw;
   logic [DATA_W-1:0] cmd_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic [SIZE_W-1:0] resp_size;
   logic              resp_err;

   modport master (
      input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata,
      output cmd_ready, resp_valid, resp_rdata, resp_size, resp_err
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_rw, cmd_wdata,
      input  cmd_ready, resp_valid, resp_rdata, resp_size, resp_err
   );

endinterface

// File: rtl/uniboard_bus_master.sv
// Uniboard register bus initiator: one transaction at a time, SETUP/STROBE/RECOVER
// sequencing of select, tristate write data and a one-cycle response pulse.
module uniboard_bus_master
   import uniboard_bus_pkg::*;
#(
   parameter int unsigned STROBE_CYCLES  = 3,
   parameter int unsigned RECOVER_CYCLES = 1
) (
   input  logic                  clk_12MHz,
   input  logic                  reset,
   uniboard_bus_master_if.master cmd_if,
   inout  logic [DATA_W-1:0]     databus,
   input  logic [SIZE_W-1:0]     reg_size,
   output logic [ADDR_W-1:0]     register_addr,
   output logic                  rw,
   output logic                  select
);

   bus_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] wdata_q;
   logic              drive_q;
   logic              accept;
   logic              strobe_done;
   logic              size_err;

   assign cmd_if.cmd_ready = (state_q == ST_IDLE);
   assign databus          = drive_q ? wdata_q : 'z;

   assign size_err = $isunknown(reg_size) || (reg_size == '0) ||
                     (32'(reg_size) > MAX_REG_BYTES);

   always_ff @(posedge clk_12MHz) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter is reloaded on every STROBE/RECOVER entry and only counts down to zero.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      accept      = 1'b0;
      strobe_done = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_if.cmd_valid) begin
               accept  = 1'b1;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            cnt_d   = CNT_W'(STROBE_CYCLES - 1);
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               strobe_done = 1'b1;
               state_d     = ST_RECOVER;
               cnt_d       = CNT_W'(RECOVER_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RECOVER: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_12MHz) begin
      if (reset) begin
         register_addr     <= '0;
         rw                <= 1'b1;
         select            <= 1'b0;
         drive_q           <= 1'b0;
         wdata_q           <= '0;
         cmd_if.resp_valid <= 1'b0;
         cmd_if.resp_rdata <= '0;
         cmd_if.resp_size  <= '0;
         cmd_if.resp_err   <= 1'b0;
      end else begin
         cmd_if.resp_valid <= 1'b0;
         if (accept) begin
            register_addr <= cmd_if.cmd_addr;
            rw            <= cmd_if.cmd_rw;
            wdata_q       <= cmd_if.cmd_wdata;
            drive_q       <= ~cmd_if.cmd_rw;
         end
         if (state_q == ST_SETUP) select <= 1'b1;
         if (strobe_done) begin
            select            <= 1'b0;
            drive_q           <= 1'b0;
            cmd_if.resp_valid <= 1'b1;
            cmd_if.resp_size  <= reg_size;
            cmd_if.resp_err   <= size_err;
            cmd_if.resp_rdata <= (size_err || !rw) ? '0 : (databus & byte_mask(reg_size));
         end
      end
   end

endmodule

// File: tb/tb_uniboard_bus_master.sv
// Directed bench for uniboard_bus_master against an expansion-style responder model.
module tb_uniboard_bus_master;
   import uniboard_bus_pkg::*;

   logic clk_12MHz = 1'b0;
   logic reset     = 1'b1;
   always #5 clk_12MHz = ~clk_12MHz;

   uniboard_bus_master_if bus_if ();
   wire  [DATA_W-1:0] databus;
   logic [SIZE_W-1:0] reg_size;
   logic [ADDR_W-1:0] register_addr;
   logic              rw;
   logic              select;

   uniboard_bus_master #(.STROBE_CYCLES(3), .RECOVER_CYCLES(1)) dut (
      .clk_12MHz     (clk_12MHz),
      .reset         (reset),
      .cmd_if        (bus_if.master),
      .databus       (databus),
      .reg_size      (reg_size),
      .register_addr (register_addr),
      .rw            (rw),
      .select        (select)
   );

   // Responder: addr 1 = 8-bit register, addr 2/3 = fixed word with size 2/5, others unmapped.
   logic [7:0]        reg1  = 8'h00;
   logic              sel_d = 1'b0;
   logic [DATA_W-1:0] tb_data;
   logic [SIZE_W-1:0] tb_size;
   logic              tb_drive;

   always_comb begin
      tb_data = '0;
      tb_size = '0;
      case (register_addr)
         8'd1: begin tb_data = {24'h0, reg1};  tb_size = 3'd1; end
         8'd2: begin tb_data = 32'hDEADBEEF;   tb_size = 3'd2; end
         8'd3: begin tb_data = 32'hDEADBEEF;   tb_size = 3'd5; end
         default: ;
      endcase
   end

   assign tb_drive = select && rw && (tb_size != 3'd0);
   assign reg_size = select ? tb_size : 3'd0;
   assign databus  = tb_drive ? tb_data : 'z;

   always @(posedge clk_12MHz) begin
      sel_d <= select;
      if (select && !sel_d && !rw && register_addr == 8'd1) reg1 <= databus[7:0];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic bus_released();
      return $isunknown(databus) || (databus == '0);
   endfunction

   // Master must never drive while rw=1, and must let go as select falls.
   logic mon_en       = 1'b0;
   logic mon_sel_prev = 1'b0;
   always @(negedge clk_12MHz) begin
      if (mon_en) begin
         if (rw === 1'b1 && !tb_drive)
            check("rw1_bus_released", 32'(bus_released()), 32'd1);
         if (mon_sel_prev && !select)
            check("release_on_select_fall", 32'(bus_released()), 32'd1);
         mon_sel_prev <= select;
      end
   end

   task automatic run_cmd(input logic [7:0] a, input logic r, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic [2:0] sz,
                          output logic er, output int hi, output int pulses);
      int   n;
      logic prev;
      @(negedge clk_12MHz);
      bus_if.cmd_addr  = a;
      bus_if.cmd_rw    = r;
      bus_if.cmd_wdata = wd;
      bus_if.cmd_valid = 1'b1;
      n = 0;
      while (bus_if.cmd_ready !== 1'b1 && n < 20) begin
         @(negedge clk_12MHz);
         n++;
      end
      check("accept_timeout", 32'(n < 20), 32'd1);
      @(negedge clk_12MHz);
      bus_if.cmd_valid = 1'b0;
      check("ready_low_after_accept", 32'(bus_if.cmd_ready), 32'd0);
      lat = 0; hi = 0; pulses = 0; prev = 1'b0;
      rd = '0; sz = '0; er = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_12MHz);
         if (select) hi++;
         if (select && !prev) pulses++;
         if (select && !r) check("write_data_on_bus", databus, wd);
         prev = select;
         if (bus_if.resp_valid) begin
            lat = k;
            rd  = bus_if.resp_rdata;
            sz  = bus_if.resp_size;
            er  = bus_if.resp_err;
            break;
         end
      end
      check("resp_timeout", 32'(lat != 0), 32'd1);
   endtask

   int          lat, hi, pulses;
   logic [31:0] rd;
   logic [2:0]  sz;
   logic        er;

   logic [7:0]  addrs [3];
   int          acc_t [3];
   int          rsp_t [3];
   logic [31:0] rsp_d [3];
   logic        rsp_e [3];
   int          gaps  [2];
   int          na, nr, ng, lowrun, nvalid;
   logic        seen_hi, prev_sel, acc_now;

   initial begin
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_addr  = '0;
      bus_if.cmd_rw    = 1'b0;
      bus_if.cmd_wdata = '0;

      // Reset values
      repeat (3) @(negedge clk_12MHz);
      check("rst_select",     32'(select), 32'd0);
      check("rst_rw",         32'(rw), 32'd1);
      check("rst_addr",       32'(register_addr), 32'd0);
      check("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
      check("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
      check("rst_resp_size",  32'(bus_if.resp_size), 32'd0);
      check("rst_resp_err",   32'(bus_if.resp_err), 32'd0);
      check("rst_cmd_ready",  32'(bus_if.cmd_ready), 32'd1);
      check("rst_bus_hiz",    32'(bus_released()), 32'd1);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Write 0xA5 to addr 1, then read it back
      run_cmd(8'd1, 1'b0, 32'h0000_00A5, lat, rd, sz, er, hi, pulses);
      check("wr_latency",   32'(lat), 32'd4);
      check("wr_sel_cycles", 32'(hi), 32'd3);
      check("wr_sel_pulses", 32'(pulses), 32'd1);
      check("wr_rdata",     rd, 32'd0);
      check("wr_size",      32'(sz), 32'd1);
      check("wr_err",       32'(er), 32'd0);
      check("wr_reg1",      32'(reg1), 32'h0000_00A5);

      run_cmd(8'd1, 1'b1, 32'hFFFF_FFFF, lat, rd, sz, er, hi, pulses);
      check("rd1_latency",   32'(lat), 32'd4);
      check("rd1_sel_cycles", 32'(hi), 32'd3);
      check("rd1_rdata",     rd, 32'h0000_00A5);
      check("rd1_size",      32'(sz), 32'd1);
      check("rd1_err",       32'(er), 32'd0);

      // Unmapped read
      run_cmd(8'h07, 1'b1, 32'd0, lat, rd, sz, er, hi, pulses);
      check("rd7_rdata", rd, 32'd0);
      check("rd7_size",  32'(sz), 32'd0);
      check("rd7_err",   32'(er), 32'd1);

      // Masking to two bytes, and an oversize reply
      run_cmd(8'd2, 1'b1, 32'd0, lat, rd, sz, er, hi, pulses);
      check("rd2_rdata", rd, 32'h0000_BEEF);
      check("rd2_size",  32'(sz), 32'd2);
      check("rd2_err",   32'(er), 32'd0);

      run_cmd(8'd3, 1'b1, 32'd0, lat, rd, sz, er, hi, pulses);
      check("rd3_rdata", rd, 32'd0);
      check("rd3_size",  32'(sz), 32'd5);
      check("rd3_err",   32'(er), 32'd1);

      // Back-to-back reads with cmd_valid held high
      addrs[0] = 8'd1; addrs[1] = 8'd2; addrs[2] = 8'h07;
      na = 0; nr = 0; ng = 0; lowrun = 0; seen_hi = 1'b0; prev_sel = 1'b0;
      @(negedge clk_12MHz);
      bus_if.cmd_addr  = addrs[0];
      bus_if.cmd_rw    = 1'b1;
      bus_if.cmd_valid = 1'b1;
      for (int t = 0; t < 40; t++) begin
         acc_now = bus_if.cmd_valid && bus_if.cmd_ready;
         if (acc_now && na < 3) begin
            acc_t[na] = t + 1;
            na++;
         end
         @(negedge clk_12MHz);
         if (acc_now) begin
            if (na < 3) bus_if.cmd_addr  = addrs[na];
            else        bus_if.cmd_valid = 1'b0;
         end
         if (bus_if.resp_valid && nr < 3) begin
            rsp_t[nr] = t + 1;
            rsp_d[nr] = bus_if.resp_rdata;
            rsp_e[nr] = bus_if.resp_err;
            nr++;
         end
         if (select && !prev_sel && seen_hi && ng < 2) begin
            gaps[ng] = lowrun;
            ng++;
         end
         if (select) begin
            seen_hi = 1'b1;
            lowrun  = 0;
         end else begin
            lowrun++;
         end
         prev_sel = select;
      end
      bus_if.cmd_valid = 1'b0;
      check("b2b_accepts",   32'(na), 32'd3);
      check("b2b_responses", 32'(nr), 32'd3);
      check("b2b_gaps_seen", 32'(ng), 32'd2);
      if (na == 3) begin
         check("b2b_spacing_01", 32'(acc_t[1] - acc_t[0]), 32'd6);
         check("b2b_spacing_12", 32'(acc_t[2] - acc_t[1]), 32'd6);
      end
      if (na == 3 && nr == 3) begin
         for (int i = 0; i < 3; i++)
            check("b2b_latency", 32'(rsp_t[i] - acc_t[i]), 32'd4);
         check("b2b_rdata0", rsp_d[0], 32'h0000_00A5);
         check("b2b_rdata1", rsp_d[1], 32'h0000_BEEF);
         check("b2b_rdata2", rsp_d[2], 32'd0);
         check("b2b_err2",   32'(rsp_e[2]), 32'd1);
      end
      // Select low through RECOVER, IDLE and SETUP between pulses
      if (ng == 2) begin
         check("b2b_gap0", 32'(gaps[0]), 32'd3);
         check("b2b_gap1", 32'(gaps[1]), 32'd3);
      end

      // Reset asserted for two cycles in the middle of a write strobe
      repeat (4) @(negedge clk_12MHz);
      bus_if.cmd_addr  = 8'd5;
      bus_if.cmd_rw    = 1'b0;
      bus_if.cmd_wdata = 32'h1234_5678;
      bus_if.cmd_valid = 1'b1;
      @(negedge clk_12MHz);
      bus_if.cmd_valid = 1'b0;
      @(negedge clk_12MHz);
      check("abort_strobe_active", 32'(select), 32'd1);
      reset = 1'b1;
      @(negedge clk_12MHz);
      check("abort_select_low",  32'(select), 32'd0);
      check("abort_bus_hiz",     32'(bus_released()), 32'd1);
      check("abort_no_resp",     32'(bus_if.resp_valid), 32'd0);
      @(negedge clk_12MHz);
      reset  = 1'b0;
      nvalid = 0;
      repeat (8) begin
         @(negedge clk_12MHz);
         if (bus_if.resp_valid) nvalid++;
      end
      check("abort_resp_count", 32'(nvalid), 32'd0);
      check("abort_ready_after", 32'(bus_if.cmd_ready), 32'd1);
      check("abort_select_idle", 32'(select), 32'd0);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uniboard_bus_master.md
# uniboard_bus_master

Initiator for the uniboard register bus. Accepts one register transaction at a time from a command source, such as the host command parser, over a valid/ready handshake. Drives `register_addr`, `rw`, `select` and, for writes, `databus`. For reads, captures `databus` and `reg_size` from the addressed peripheral and returns them as a one-cycle response pulse. It is the only driver of `select`, `rw` and `register_addr` on the bus.

## Interface
- STROBE_CYCLES, 3: cycles `select` is held high per transaction; legal range 2..15.
- RECOVER_CYCLES, 1: cycles `select` is held low after a transaction before the next setup; legal range 1..15.
- clk_12MHz  in  1  bus clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  8  target register address.
- cmd_rw  in  1  0 = write, 1 = read.
- cmd_wdata  in  32  write data (ignored for reads).
- resp_valid  out  1  one-cycle pulse per completed transaction.
- resp_rdata  out  32  read data, masked to `resp_size` bytes; 0 for writes and errors.
- resp_size  out  3  `reg_size` sampled from the bus.
- resp_err  out  1  set when the sampled size is 0, above 4, or unknown.
- databus  inout  32  driven only during write SETUP/STROBE, otherwise high-Z.
- reg_size  in  3  reply size from the selected peripheral; board-level pulldowns make it read as 0 when no peripheral drives it.
- register_addr  out  8  registered bus address.
- rw  out  1  registered bus direction.
- select  out  1  registered strobe.

## Operation
- States: IDLE, SETUP, STROBE, RECOVER.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch addr, rw and wdata, then go to SETUP.
- **SETUP** (1 cycle)
  - `register_addr` and `rw` present the latched command; `select`=0.
  - For writes, `databus` is driven with wdata.
- **STROBE** (STROBE_CYCLES cycles)
  - `select`=1; addr, rw and write data held stable.
  - Peripherals detect the `select` rising edge at the posedge ending the first STROBE cycle. Write data is committed there and read data is valid from the second STROBE cycle.
  - At the posedge ending the last STROBE cycle: sample `databus` and `reg_size`, set `select`<=0, release `databus`, assert `resp_valid`, go to RECOVER.
- **RECOVER** (RECOVER_CYCLES cycles)
  - `select`=0, ensuring peripherals see `select` low before the next edge.
  - Return to IDLE.
- Response formation:
  - size = sampled `reg_size`.
  - err = (size==0) or (size>4) or (sample contains x/z).
  - rdata = err or write ? 0 : (databus & mask), where mask = size bytes of ones from bit 0 (size 1 → 0xFF, 4 → 0xFFFFFFFF).
- Write responses still report `resp_size` and `resp_err`, so the host can detect unmapped writes.
- Commands are never dropped: `cmd_valid` outside IDLE waits.

## Timing
- Reset values:
  - `select`=0, `rw`=1, `register_addr`=0, `databus` high-Z.
  - `resp_valid`=0, `resp_rdata`=0, `resp_size`=0, `resp_err`=0.
  - state IDLE, so `cmd_ready`=1 from the first cycle after reset.
- Handshake at posedge E0 (`cmd_valid`&`cmd_ready`):
  - SETUP during E0..E1.
  - `select` high E1..E1+STROBE_CYCLES.
  - `resp_valid` high for exactly the cycle after posedge E1+STROBE_CYCLES.
  - Accept-to-response = STROBE_CYCLES+1 cycles (4 at defaults).
- Back-to-back with `cmd_valid` held high: one transaction per 2+STROBE_CYCLES+RECOVER_CYCLES cycles (6 at defaults), i.e. IDLE + SETUP + STROBE + RECOVER.
- `resp_valid` does not wait for a ready signal. The consumer must accept it in the cycle it is asserted.
- Reset mid-transaction, any state:
  - next posedge forces `select`=0, releases `databus`, clears state to IDLE;
  - no `resp_valid` is issued for the aborted command.
- The strobe counter is 4 bits. It is reloaded on each STROBE/RECOVER entry and never wraps.

## Structure
- Shared package/header `uniboard_bus_pkg`:
  - state encoding;
  - bus widths (ADDR_W=8, DATA_W=32, SIZE_W=3);
  - constant MAX_REG_BYTES=4.
- The expansion peripheral and the other uniboard responders share these widths.
- Single module, no sub-modules. The byte-mask generator is a function in the package.

## Test plan
- Reset: hold `reset` 2 cycles mid-STROBE → `select`=0 next cycle, `databus` high-Z, no `resp_valid`, `cmd_ready`=1 afterward.
- Write then read to an expansion-style responder model:
  - stimulus: write addr 1 with 0x000000A5, then read addr 1.
  - write: one `select` pulse of 3 cycles, the model's register becomes 0xA5.
  - read: resp_rdata=0x000000A5, resp_size=1, resp_err=0, resp_valid exactly 4 cycles after accept.
- Unmapped read of addr 0x07: responder returns size 0 → resp_err=1, resp_rdata=0, resp_size=0.
- Masking: responder model returns 0xDEADBEEF with size 2 → resp_rdata=0x0000BEEF, resp_err=0. Size 5 → resp_err=1, resp_rdata=0.
- Back-to-back: three reads with `cmd_valid` held high → accepts spaced 6 cycles apart, `select` low at least 1 cycle between pulses, three `resp_valid` pulses in order.
- Bus contention: across a write followed by a read, `databus` is never driven by the master while `rw`=1, and is released in the cycle `select` falls.
